wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Write-back stage of the pipelined MIPS core; it drives the register file write port (RegWrite, Write_addr, Write_data).
- Holds the MEM/WB pipeline register and performs load-data alignment and sign/zero extension.
- Merges late results from the multi-cycle divider through a 2-entry buffer.
- Pipeline writes always take priority; divider results use free write-port cycles.

Parameters:
- bit_size, 32, data width
- DIV_DEPTH, 2, divider result buffer entries (power of two)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- stall  in  1  hold the MEM/WB register
- flush  in  1  load a bubble instead of the MEM entry
- mem_valid  in  1  MEM stage holds a real instruction
- mem_reg_write  in  1  instruction writes a GPR
- mem_mem_to_reg  in  1  1 selects load data, 0 selects ALU result
- mem_load_type  in  3  load kind (package constants)
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_alu_result  in  bit_size  ALU result
- mem_load_data  in  bit_size  raw word from data memory
- mem_write_addr  in  5  destination register
- div_valid  in  1  divider offers a result
- div_ready  out  1  buffer can accept a result
- div_write_addr  in  5  divider destination register
- div_data  in  bit_size  divider result
- div_pending  out  1  buffer non-empty (for the hazard unit)
- RegWrite  out  1  register file write enable
- Write_addr  out  5  register file write address
- Write_data  out  bit_size  register file write data

Behaviour:
- Reset (rst=0, asynchronous):
  - stage register cleared (valid=0, done=0).
  - buffer emptied.
  - RegWrite=0, Write_addr=0, Write_data=0, div_ready=1, div_pending=0.
- Stage register update on posedge clk:
  - stall=1: hold; flush is ignored.
  - stall=0, flush=1: load a bubble (valid=0).
  - otherwise: load the MEM fields; valid=mem_valid; done=0.
- Alignment happens at capture (registered result), little-endian byte lanes:
  - LW: whole word.
  - LB/LBU: byte mem_addr_lo, sign/zero extended.
  - LH/LHU: halfword mem_addr_lo[1], sign/zero extended; mem_addr_lo[0] is ignored (misalignment is trapped upstream).
  - mem_to_reg=0: ALU result.
- Pipeline write request:
  - pipe_req = valid & reg_write & ~done & (addr!=0).
  - The stage write is presented exactly once. done is set at the posedge where pipe_req was presented, so a stalled entry is not rewritten and frees the port.
- Output selection (combinational from registers):
  - pipe_req=1: RegWrite=1 with the stage address and data.
  - else buffer non-empty: RegWrite=1 with the head entry; head pops at that posedge.
  - else RegWrite=0, Write_addr=0, Write_data=0.
- Divider handshake:
  - A result is accepted at a posedge with div_valid & div_ready.
  - div_ready = buffer not full (combinational from count only; not dependent on div_valid).
  - Results with div_write_addr=0 are accepted and discarded.
  - Minimum latency is 1 cycle from acceptance to RegWrite.
  - Simultaneous push and pop when the buffer is full is not allowed, because div_ready=0 when full.
  - Push and pop in the same cycle at count=1 keeps count=1.
- Ordering:
  - Buffer results are written in FIFO order.
  - WAW between divider and pipeline is not checked here; the hazard unit uses div_pending to avoid it.
- Starvation: back-to-back pipeline writes may delay the buffer indefinitely; div_ready=0 then backpressures the divider.
- Reset asserted mid-operation discards the buffered results and the stage entry; no partial write occurs.

Decomposition:
- Package core_pkg:
  - LT_LW=0, LT_LB=1, LT_LBU=2, LT_LH=3, LT_LHU=4.
  - DIV_DEPTH default.
  - REG_ZERO=5'd0.
- Sub-module wb_div_fifo: DIV_DEPTH-entry FIFO with valid/ready push side, pop strobe, count, and the same clk/rst.

Test Plan:
- Reset: rst=0 mid-traffic with 2 buffered entries -> RegWrite=0, div_pending=0, div_ready=1; no write after release.
- LB, load_data=32'h80FF7F01, addr_lo=2'd3 -> Write_data=32'hFFFFFF80. LBU with addr_lo=1 -> 32'h0000007F. LH with addr_lo=2 -> 32'hFFFF80FF.
- Stall: entry (addr=5, data=32'h1234) held 4 cycles by stall=1 -> exactly one RegWrite cycle, addr=5, data=32'h1234. A buffered divider result (addr 7) is written in the second stalled cycle.
- Priority: div result (addr 9, 32'hA) accepted while pipeline writes r3, r4 back-to-back -> r3, r4, then r9 on the next idle cycle.
- Full buffer: 3 div_valid cycles with the pipeline writing every cycle -> div_ready=0 after 2 acceptances; third result held until a pop, then accepted.
- Zero register: pipeline write to r0 and a div result to r0 -> RegWrite never asserted; div_pending=0 after acceptance.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and types for the core write-back path
// Contents:
//   load_type_e   : load kinds carried on mem_load_type
//   DIV_DEPTH_DFLT: default depth of the divider result buffer
//   REG_ZERO      : hard-wired zero register address
package core_pkg;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LB  = 3'd1,
      LT_LBU = 3'd2,
      LT_LH  = 3'd3,
      LT_LHU = 3'd4
   } load_type_e;

   localparam int         DIV_DEPTH_DFLT = 2;
   localparam logic [4:0] REG_ZERO       = 5'd0;

endpackage

// File: rtl/wb_div_fifo.sv
// rtl/wb_div_fifo.sv - small FIFO buffering late divider results
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   push_valid/ready : push handshake; ready = not full (count only)
//   push_data        : entry to store
//   pop              : drop head at this posedge (ignored when empty)
//   head_data        : current head entry
//   count            : number of stored entries
module wb_div_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int              PW       = $clog2(DEPTH);
   localparam int              CW       = PW + 1;
   localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign push_ready = (count_q != FULL_CNT);
   assign do_push    = push_valid & push_ready;
   assign do_pop     = pop & (count_q != '0);
   assign head_data  = mem_q[rd_ptr_q];
   assign count      = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - write-back stage: MEM/WB register, load alignment, divider merge
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   stall, flush             : MEM/WB register control (stall wins)
//   mem_*                    : MEM stage instruction fields
//   div_valid/ready/...      : divider result handshake
//   div_pending              : divider buffer non-empty
//   RegWrite/Write_addr/data : register file write port
module wb_unit
   import core_pkg::*;
#(
   parameter int bit_size  = 32,
   parameter int DIV_DEPTH = DIV_DEPTH_DFLT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                mem_valid,
   input  logic                mem_reg_write,
   input  logic                mem_mem_to_reg,
   input  logic [2:0]          mem_load_type,
   input  logic [1:0]          mem_addr_lo,
   input  logic [bit_size-1:0] mem_alu_result,
   input  logic [bit_size-1:0] mem_load_data,
   input  logic [4:0]          mem_write_addr,
   input  logic                div_valid,
   output logic                div_ready,
   input  logic [4:0]          div_write_addr,
   input  logic [bit_size-1:0] div_data,
   output logic                div_pending,
   output logic                RegWrite,
   output logic [4:0]          Write_addr,
   output logic [bit_size-1:0] Write_data
);

   localparam int EW = bit_size + 5;

   logic                valid_q, valid_d;
   logic                rw_q, rw_d;
   logic                done_q, done_d;
   logic [4:0]          addr_q, addr_d;
   logic [bit_size-1:0] data_q, data_d;

   logic [bit_size-1:0] byte_shift, half_shift, aligned;
   logic                pipe_req, fifo_pop;
   logic [EW-1:0]       fifo_head;
   logic [$clog2(DIV_DEPTH):0] fifo_count;

   // Little-endian lanes: move the addressed byte/halfword down to bit 0.
   assign byte_shift = mem_load_data >> {mem_addr_lo, 3'b000};
   assign half_shift = mem_load_data >> {mem_addr_lo[1], 4'b0000};

   always_comb begin
      aligned = mem_load_data;
      case (mem_load_type)
         LT_LB:   aligned = {{(bit_size-8){byte_shift[7]}}, byte_shift[7:0]};
         LT_LBU:  aligned = {{(bit_size-8){1'b0}}, byte_shift[7:0]};
         LT_LH:   aligned = {{(bit_size-16){half_shift[15]}}, half_shift[15:0]};
         LT_LHU:  aligned = {{(bit_size-16){1'b0}}, half_shift[15:0]};
         default: aligned = mem_load_data;
      endcase
   end

   assign pipe_req = valid_q & rw_q & ~done_q & (addr_q != REG_ZERO);

   always_comb begin
      valid_d = valid_q;
      rw_d    = rw_q;
      done_d  = done_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (stall) begin
         // A held entry writes once, then frees the port for the buffer.
         done_d = done_q | pipe_req;
      end else if (flush) begin
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         valid_d = mem_valid;
         rw_d    = mem_reg_write;
         done_d  = 1'b0;
         addr_d  = mem_write_addr;
         data_d  = mem_mem_to_reg ? aligned : mem_alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rw_q    <= rw_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign div_pending = (fifo_count != '0);
   assign fifo_pop    = ~pipe_req & div_pending;

   // r0 results complete the handshake but are never stored.
   wb_div_fifo #(
      .WIDTH (EW),
      .DEPTH (DIV_DEPTH)
   ) u_div_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (div_valid & (div_write_addr != REG_ZERO)),
      .push_ready (div_ready),
      .push_data  ({div_write_addr, div_data}),
      .pop        (fifo_pop),
      .head_data  (fifo_head),
      .count      (fifo_count)
   );

   always_comb begin
      RegWrite   = 1'b0;
      Write_addr = '0;
      Write_data = '0;
      if (pipe_req) begin
         RegWrite   = 1'b1;
         Write_addr = addr_q;
         Write_data = data_q;
      end else if (div_pending) begin
         RegWrite   = 1'b1;
         Write_addr = fifo_head[EW-1:bit_size];
         Write_data = fifo_head[bit_size-1:0];
      end
   end

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed self-checking bench for wb_unit
module tb_wb_unit;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        mem_valid = 1'b0, mem_reg_write = 1'b0, mem_mem_to_reg = 1'b0;
   logic [2:0]  mem_load_type = 3'd0;
   logic [1:0]  mem_addr_lo = 2'd0;
   logic [31:0] mem_alu_result = '0, mem_load_data = '0;
   logic [4:0]  mem_write_addr = '0;
   logic        div_valid = 1'b0;
   logic        div_ready;
   logic [4:0]  div_write_addr = '0;
   logic [31:0] div_data = '0;
   logic        div_pending;
   logic        RegWrite;
   logic [4:0]  Write_addr;
   logic [31:0] Write_data;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_unit #(.bit_size(32), .DIV_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_mem_to_reg(mem_mem_to_reg), .mem_load_type(mem_load_type),
      .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
      .mem_load_data(mem_load_data), .mem_write_addr(mem_write_addr),
      .div_valid(div_valid), .div_ready(div_ready),
      .div_write_addr(div_write_addr), .div_data(div_data),
      .div_pending(div_pending), .RegWrite(RegWrite),
      .Write_addr(Write_addr), .Write_data(Write_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input string tag, input logic rw, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".we"}, 64'(RegWrite), 64'(rw));
      chk({tag, ".addr"}, 64'(Write_addr), 64'(a));
      chk({tag, ".data"}, 64'(Write_data), 64'(d));
   endtask

   // Inputs change at negedge; one call moves through a posedge to the next negedge.
   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pipe(input logic [4:0] a, input logic m2r, input logic [2:0] lt,
                       input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] ld);
      mem_valid      = 1'b1;
      mem_reg_write  = 1'b1;
      mem_write_addr = a;
      mem_mem_to_reg = m2r;
      mem_load_type  = lt;
      mem_addr_lo    = lo;
      mem_alu_result = alu;
      mem_load_data  = ld;
   endtask

   task automatic alu_op(input logic [4:0] a, input logic [31:0] v);
      pipe(a, 1'b0, LT_LW, 2'd0, v, 32'h0);
   endtask

   task automatic idle;
      mem_valid     = 1'b0;
      mem_reg_write = 1'b0;
   endtask

   task automatic div(input logic v, input logic [4:0] a, input logic [31:0] d);
      div_valid      = v;
      div_write_addr = a;
      div_data       = d;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      #1;
      expect_wr("reset", 1'b0, 5'd0, 32'h0);
      chk("reset.ready", 64'(div_ready), 64'd1);
      chk("reset.pending", 64'(div_pending), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Load alignment
      pipe(5'd1, 1'b1, LT_LB, 2'd3, 32'h0, 32'h80FF7F01);
      cyc; expect_wr("lb3", 1'b1, 5'd1, 32'hFFFFFF80);
      pipe(5'd2, 1'b1, LT_LBU, 2'd1, 32'h0, 32'h80FF7F01);
      cyc; expect_wr("lbu1", 1'b1, 5'd2, 32'h0000007F);
      pipe(5'd3, 1'b1, LT_LH, 2'd2, 32'h0, 32'h80FF7F01);
      cyc; expect_wr("lh2", 1'b1, 5'd3, 32'hFFFF80FF);
      pipe(5'd4, 1'b1, LT_LHU, 2'd2, 32'h0, 32'h80FF7F01);
      cyc; expect_wr("lhu2", 1'b1, 5'd4, 32'h000080FF);
      pipe(5'd5, 1'b1, LT_LH, 2'd1, 32'h0, 32'h80FF7F01);
      cyc; expect_wr("lh1", 1'b1, 5'd5, 32'h00007F01);
      pipe(5'd6, 1'b1, LT_LW, 2'd0, 32'h0, 32'h80FF7F01);
      cyc; expect_wr("lw", 1'b1, 5'd6, 32'h80FF7F01);
      pipe(5'd7, 1'b0, LT_LB, 2'd3, 32'hCAFE0001, 32'h80FF7F01);
      cyc; expect_wr("alu", 1'b1, 5'd7, 32'hCAFE0001);

      // Flush loads a bubble
      alu_op(5'd8, 32'h88);
      flush = 1'b1;
      cyc; expect_wr("flush", 1'b0, 5'd0, 32'h0);
      flush = 1'b0;
      idle;
      cyc; expect_wr("idle", 1'b0, 5'd0, 32'h0);

      // Stall: entry written once, divider result fills the second stalled cycle
      alu_op(5'd5, 32'h1234);
      cyc; expect_wr("stall.c0", 1'b1, 5'd5, 32'h1234);
      stall = 1'b1;
      idle;
      div(1'b1, 5'd7, 32'h77);
      cyc; expect_wr("stall.c1", 1'b1, 5'd7, 32'h77);
      div(1'b0, 5'd0, 32'h0);
      cyc; expect_wr("stall.c2", 1'b0, 5'd0, 32'h0);
      cyc; expect_wr("stall.c3", 1'b0, 5'd0, 32'h0);
      cyc; expect_wr("stall.c4", 1'b0, 5'd0, 32'h0);
      stall = 1'b0;
      cyc; expect_wr("stall.rel", 1'b0, 5'd0, 32'h0);

      // Priority: pipeline r3, r4 before buffered r9
      alu_op(5'd3, 32'h33);
      div(1'b1, 5'd9, 32'hA);
      cyc; expect_wr("prio.r3", 1'b1, 5'd3, 32'h33);
      alu_op(5'd4, 32'h44);
      div(1'b0, 5'd0, 32'h0);
      cyc; expect_wr("prio.r4", 1'b1, 5'd4, 32'h44);
      chk("prio.pending", 64'(div_pending), 64'd1);
      idle;
      cyc; expect_wr("prio.r9", 1'b1, 5'd9, 32'hA);
      cyc; expect_wr("prio.idle", 1'b0, 5'd0, 32'h0);
      chk("prio.pending0", 64'(div_pending), 64'd0);

      // Full buffer backpressure
      alu_op(5'd10, 32'h100);
      div(1'b1, 5'd11, 32'hB11);
      cyc; expect_wr("full.r10", 1'b1, 5'd10, 32'h100);
      chk("full.ready1", 64'(div_ready), 64'd1);
      alu_op(5'd14, 32'h140);
      div(1'b1, 5'd12, 32'hB12);
      cyc; expect_wr("full.r14", 1'b1, 5'd14, 32'h140);
      chk("full.ready0", 64'(div_ready), 64'd0);
      alu_op(5'd15, 32'h150);
      div(1'b1, 5'd13, 32'hB13);
      cyc; expect_wr("full.r15", 1'b1, 5'd15, 32'h150);
      chk("full.ready0b", 64'(div_ready), 64'd0);
      idle;
      cyc; expect_wr("full.r11", 1'b1, 5'd11, 32'hB11);
      chk("full.ready0c", 64'(div_ready), 64'd0);
      cyc; expect_wr("full.r12", 1'b1, 5'd12, 32'hB12);
      chk("full.ready1b", 64'(div_ready), 64'd1);
      cyc; expect_wr("full.r13", 1'b1, 5'd13, 32'hB13);
      chk("full.pending", 64'(div_pending), 64'd1);
      div(1'b0, 5'd0, 32'h0);
      cyc; expect_wr("full.idle", 1'b0, 5'd0, 32'h0);
      chk("full.pending0", 64'(div_pending), 64'd0);

      // Zero register
      alu_op(5'd0, 32'hDEAD);
      div(1'b1, 5'd0, 32'hBEEF);
      cyc; expect_wr("r0.c0", 1'b0, 5'd0, 32'h0);
      chk("r0.pending", 64'(div_pending), 64'd0);
      idle;
      div(1'b0, 5'd0, 32'h0);
      cyc; expect_wr("r0.c1", 1'b0, 5'd0, 32'h0);

      // Reset mid-traffic with two buffered entries
      alu_op(5'd20, 32'h200);
      div(1'b1, 5'd21, 32'hC21);
      cyc;
      alu_op(5'd23, 32'h230);
      div(1'b1, 5'd22, 32'hC22);
      cyc;
      chk("rst.pre_pending", 64'(div_pending), 64'd1);
      chk("rst.pre_ready", 64'(div_ready), 64'd0);
      rst = 1'b0;
      #1;
      expect_wr("rst.mid", 1'b0, 5'd0, 32'h0);
      chk("rst.pending", 64'(div_pending), 64'd0);
      chk("rst.ready", 64'(div_ready), 64'd1);
      idle;
      div(1'b0, 5'd0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      cyc; expect_wr("rst.after1", 1'b0, 5'd0, 32'h0);
      cyc; expect_wr("rst.after2", 1'b0, 5'd0, 32'h0);
      chk("rst.after_pending", 64'(div_pending), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
